// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI master buffer.
//   spi_state_t   : controller FSM states (IDLE -> SETUP -> XFER -> HOLD -> IDLE)
//   spi_byte_t    : one SPI data byte
//   SPI_MAX_BYTES : largest number of bytes moved by one transfer
//   clamp_len     : limits a requested byte count to SPI_MAX_BYTES
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_MAX_BYTES = 4;

    typedef logic [7:0] spi_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    // Requests above the buffer depth are truncated to the buffer depth.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len > 3'(SPI_MAX_BYTES)) begin
            return 3'(SPI_MAX_BYTES);
        end
        return len;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Half-period tick generator for the SPI master. A counter runs 0..CLK_DIV-1
// while enabled and o_tick is high on its last count, so one tick marks the
// end of every CLK_DIV-cycle SCLK half-period. Disabled, the counter sits at 0
// so the first half-period after enabling is always a full CLK_DIV cycles.
// Ports:
//   i_clk   : system clock, rising edge
//   i_reset : asynchronous active-high reset
//   i_en    : count enable (controller outside IDLE)
//   o_tick  : end of current half-period
// -----------------------------------------------------------------------------
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [7:0] LP_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= 8'd0;
        end else if (!i_en || (r_cnt == LP_LAST)) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tick = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/spi_master_buffer.sv
// -----------------------------------------------------------------------------
// spi_master_buffer
// Mode-0 SPI master that shifts out up to four latched command bytes and
// captures the same number of bytes from MISO into a small receive buffer.
// Chip select is low for CLK_DIV*(16*N+2) cycles: one CLK_DIV setup period,
// 16 half-periods per byte, one CLK_DIV hold period.
// Ports:
//   sys_clk, reset     : clock (rising edge) and asynchronous active-high reset
//   start, tx_len      : transfer request and byte count (0 = no-op, >4 -> 4)
//   tx0..tx3           : bytes to send, tx0 first, MSB first
//   busy, done         : transfer in progress / one-cycle completion pulse
//   rx0..rx3, rx_count : captured bytes (rx0 first) and how many were written
//   spi_sclk, spi_cs_n, spi_mosi, spi_miso : SPI bus
// -----------------------------------------------------------------------------
module spi_master_buffer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] tx_len,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    input  logic [7:0] tx2,
    input  logic [7:0] tx3,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx0,
    output logic [7:0] rx1,
    output logic [7:0] rx2,
    output logic [7:0] rx3,
    output logic [2:0] rx_count,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    spi_state_t r_state,      w_state_next;
    logic       r_cs_n,       w_cs_n_next;
    logic       r_sclk,       w_sclk_next;
    logic       r_busy,       w_busy_next;
    logic       r_done,       w_done_next;
    logic [2:0] r_rx_count,   w_rx_count_next;
    logic [2:0] r_len,        w_len_next;
    logic [2:0] r_bit_cnt,    w_bit_cnt_next;
    logic [1:0] r_byte_idx,   w_byte_idx_next;
    spi_byte_t  r_tx_shift,   w_tx_shift_next;
    logic [6:0] r_rx_shift,   w_rx_shift_next;
    spi_byte_t  r_tx_lat [SPI_MAX_BYTES];
    spi_byte_t  w_tx_lat_next [SPI_MAX_BYTES];
    spi_byte_t  r_rx [SPI_MAX_BYTES];
    spi_byte_t  w_rx_next [SPI_MAX_BYTES];

    logic       w_tick;
    logic [2:0] w_len_clamped;
    logic [1:0] w_next_idx;
    logic       w_last_byte;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .i_clk   (sys_clk),
        .i_reset (reset),
        .i_en    (r_state != ST_IDLE),
        .o_tick  (w_tick)
    );

    assign w_len_clamped = clamp_len(tx_len);
    assign w_next_idx    = r_byte_idx + 2'd1;
    assign w_last_byte   = ({1'b0, r_byte_idx} == (r_len - 3'd1));

    // State and all outputs are registers; the combinational block below only
    // computes their next values.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_count <= 3'd0;
            r_len      <= 3'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_tx_shift <= 8'h00;
            r_rx_shift <= 7'h00;
            for (int i = 0; i < SPI_MAX_BYTES; i++) begin
                r_tx_lat[i] <= 8'h00;
                r_rx[i]     <= 8'h00;
            end
        end else begin
            r_state    <= w_state_next;
            r_cs_n     <= w_cs_n_next;
            r_sclk     <= w_sclk_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_rx_count <= w_rx_count_next;
            r_len      <= w_len_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_byte_idx <= w_byte_idx_next;
            r_tx_shift <= w_tx_shift_next;
            r_rx_shift <= w_rx_shift_next;
            for (int i = 0; i < SPI_MAX_BYTES; i++) begin
                r_tx_lat[i] <= w_tx_lat_next[i];
                r_rx[i]     <= w_rx_next[i];
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cs_n_next     = r_cs_n;
        w_sclk_next     = r_sclk;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_rx_count_next = r_rx_count;
        w_len_next      = r_len;
        w_bit_cnt_next  = r_bit_cnt;
        w_byte_idx_next = r_byte_idx;
        w_tx_shift_next = r_tx_shift;
        w_rx_shift_next = r_rx_shift;
        w_tx_lat_next   = r_tx_lat;
        w_rx_next       = r_rx;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_tx_lat_next[0] = tx0;
                    w_tx_lat_next[1] = tx1;
                    w_tx_lat_next[2] = tx2;
                    w_tx_lat_next[3] = tx3;
                    w_len_next       = w_len_clamped;
                    w_rx_count_next  = 3'd0;
                    if (w_len_clamped == 3'd0) begin
                        // Zero-length request completes without touching the bus.
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next    = ST_SETUP;
                        w_cs_n_next     = 1'b0;
                        w_sclk_next     = 1'b0;
                        w_busy_next     = 1'b1;
                        w_bit_cnt_next  = 3'd0;
                        w_byte_idx_next = 2'd0;
                        // MOSI is the MSB of the shift register, so loading
                        // tx0 presents tx0[7] during setup.
                        w_tx_shift_next = tx0;
                    end
                end
            end

            ST_SETUP: begin
                if (w_tick) begin
                    w_state_next = ST_XFER;
                end
            end

            ST_XFER: begin
                if (w_tick) begin
                    if (!r_sclk) begin
                        // Rising edge: sample MISO.
                        w_sclk_next     = 1'b1;
                        w_rx_shift_next = {r_rx_shift[5:0], spi_miso};
                        if (r_bit_cnt == 3'd7) begin
                            w_rx_next[r_byte_idx] = {r_rx_shift, spi_miso};
                            w_rx_count_next       = r_rx_count + 3'd1;
                        end
                    end else begin
                        // Falling edge: advance MOSI.
                        w_sclk_next    = 1'b0;
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        if (r_bit_cnt != 3'd7) begin
                            w_tx_shift_next = {r_tx_shift[6:0], 1'b0};
                        end else if (w_last_byte) begin
                            w_tx_shift_next = 8'h00;
                            w_state_next    = ST_HOLD;
                        end else begin
                            // Next byte's MSB goes out on this same edge: no gap.
                            w_byte_idx_next = w_next_idx;
                            w_tx_shift_next = r_tx_lat[w_next_idx];
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                    w_cs_n_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rx_count = r_rx_count;
    assign rx0      = r_rx[0];
    assign rx1      = r_rx[1];
    assign rx2      = r_rx[2];
    assign rx3      = r_rx[3];
    assign spi_sclk = r_sclk;
    assign spi_cs_n = r_cs_n;
    assign spi_mosi = r_tx_shift[7];

endmodule

// File: tb/tb_spi_master_buffer.sv
// -----------------------------------------------------------------------------
// tb_spi_master_buffer
// Two instances of spi_master_buffer (index 0: CLK_DIV=2, index 1: CLK_DIV=1)
// share one clock. A negedge monitor plays the SPI slave (or loops MOSI back
// to MISO), records the MOSI stream and counts bus events. Expected results
// come from the transfer rules: bytes sent MSB first, slave bytes returned,
// CS low for CLK_DIV*(16N+2) cycles, 8N rising SCLK edges, one done pulse.
// -----------------------------------------------------------------------------
module tb_spi_master_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_s   = 2'b11;
    logic [1:0] start_s = 2'b00;
    logic [2:0] len_s [2];
    logic [7:0] tx_s  [2][4];
    logic [1:0] busy_w, done_w, sclk_w, cs_w, mosi_w, miso_s;
    logic [7:0] rx_w  [2][4];
    logic [2:0] cnt_w [2];

    logic [1:0]  loop_s    = 2'b00;
    logic [1:0]  slave_bit = 2'b00;
    logic [31:0] slave_w [2];

    assign miso_s = (loop_s & mosi_w) | (~loop_s & slave_bit);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            spi_master_buffer #(
                .CLK_DIV ((gi == 0) ? 2 : 1)
            ) u_dut (
                .sys_clk  (clk),
                .reset    (rst_s[gi]),
                .start    (start_s[gi]),
                .tx_len   (len_s[gi]),
                .tx0      (tx_s[gi][0]),
                .tx1      (tx_s[gi][1]),
                .tx2      (tx_s[gi][2]),
                .tx3      (tx_s[gi][3]),
                .busy     (busy_w[gi]),
                .done     (done_w[gi]),
                .rx0      (rx_w[gi][0]),
                .rx1      (rx_w[gi][1]),
                .rx2      (rx_w[gi][2]),
                .rx3      (rx_w[gi][3]),
                .rx_count (cnt_w[gi]),
                .spi_sclk (sclk_w[gi]),
                .spi_cs_n (cs_w[gi]),
                .spi_mosi (mosi_w[gi]),
                .spi_miso (miso_s[gi])
            );
        end
    endgenerate

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_rx [2][4];

    // Monitor state (written only by the monitor process).
    int          low_cnt  [2] = '{0, 0};
    int          rise_cnt [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          cs_rise  [2] = '{0, 0};
    int          gap_bad  [2] = '{0, 0};
    int          pos      [2] = '{0, 0};
    int          last_rise[2] = '{-1, -1};
    int          cyc      [2] = '{0, 0};
    logic [31:0] mosi_cap [2];
    logic [1:0]  sclk_prev = 2'b00;
    logic [1:0]  cs_prev   = 2'b11;

    function automatic int div_of(input int s);
        return (s == 0) ? 2 : 1;
    endfunction

    function automatic logic sbit(input int s, input int p);
        logic [31:0] w;
        w = slave_w[s];
        if (p < 32) return w[31 - p];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_w[i] == 1'b0) low_cnt[i]++;
            if (!cs_w[i] && cs_prev[i]) begin
                pos[i]       = 0;
                slave_bit[i] = sbit(i, 0);
                last_rise[i] = -1;
            end
            if (sclk_w[i] && !sclk_prev[i]) begin
                rise_cnt[i]++;
                mosi_cap[i] = {mosi_cap[i][30:0], mosi_w[i]};
                if (last_rise[i] >= 0 && (cyc[i] - last_rise[i]) != 2 * div_of(i))
                    gap_bad[i]++;
                last_rise[i] = cyc[i];
            end
            if (!sclk_w[i] && sclk_prev[i] && !cs_w[i]) begin
                pos[i]++;
                slave_bit[i] = sbit(i, pos[i]);
            end
            if (done_w[i]) done_cnt[i]++;
            if (cs_w[i] && !cs_prev[i]) begin
                cs_rise[i]++;
                last_rise[i] = -1;
            end
            sclk_prev[i] = sclk_w[i];
            cs_prev[i]   = cs_w[i];
            cyc[i]++;
        end
    end

    // Every task starts and ends 1 time unit after a rising clock edge.
    task automatic run_xfer(input int sel, input logic [2:0] len, input logic [31:0] txw,
                            input logic [31:0] sw, input bit loop, input bit extra,
                            input string name);
        int n, lc0, rc0, dc0, cr0, gb0, cycles, dv;
        bit got;
        logic [31:0] exp_bits, mask;
        dv = div_of(sel);
        n  = (len > 3'd4) ? 4 : int'(len);
        slave_w[sel] = sw;
        loop_s[sel]  = loop;
        lc0 = low_cnt[sel]; rc0 = rise_cnt[sel]; dc0 = done_cnt[sel];
        cr0 = cs_rise[sel]; gb0 = gap_bad[sel];
        for (int k = 0; k < 4; k++) tx_s[sel][k] = txw[31 - 8 * k -: 8];
        len_s[sel]   = len;
        start_s[sel] = 1'b1;
        @(posedge clk); #1;
        start_s[sel] = 1'b0;
        if (n == 0) begin
            total++;
            if (done_w[sel] !== 1'b1 || cs_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || cnt_w[sel] !== 3'd0) begin
                bad++;
                $display("FAIL %s noop_pulse: done=%b cs_n=%b busy=%b rx_count=%0d required 1 1 0 0",
                         name, done_w[sel], cs_w[sel], busy_w[sel], cnt_w[sel]);
            end
            @(posedge clk); #1;
            total++;
            if (done_w[sel] !== 1'b0) begin
                bad++;
                $display("FAIL %s noop_pulse_width: done=%b required 0", name, done_w[sel]);
            end
        end else begin
            total++;
            if (busy_w[sel] !== 1'b1 || cs_w[sel] !== 1'b0) begin
                bad++;
                $display("FAIL %s start_accept: busy=%b cs_n=%b required 1 0", name, busy_w[sel], cs_w[sel]);
            end
            got = 1'b0;
            for (cycles = 0; cycles < 3000 && !got; cycles++) begin
                start_s[sel] = extra && (cycles == 20);
                @(posedge clk); #1;
                if (done_w[sel]) got = 1'b1;
            end
            start_s[sel] = 1'b0;
            total++;
            if (!got || busy_w[sel] !== 1'b0 || cs_w[sel] !== 1'b1) begin
                bad++;
                $display("FAIL %s finish: done_seen=%b busy=%b cs_n=%b required 1 0 1",
                         name, got, busy_w[sel], cs_w[sel]);
            end
            @(posedge clk); #1;
            total++;
            if (done_w[sel] !== 1'b0) begin
                bad++;
                $display("FAIL %s done_width: done=%b required 0", name, done_w[sel]);
            end
        end
        for (int k = 0; k < n; k++)
            exp_rx[sel][k] = loop ? txw[31 - 8 * k -: 8] : sw[31 - 8 * k -: 8];
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (cnt_w[sel] !== 3'(n)) begin
            bad++;
            $display("FAIL %s rx_count: got=%0d required=%0d", name, cnt_w[sel], n);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rx_w[sel][k] !== exp_rx[sel][k]) begin
                bad++;
                $display("FAIL %s rx%0d: got=%h required=%h", name, k, rx_w[sel][k], exp_rx[sel][k]);
            end
        end
        total++;
        if (low_cnt[sel] - lc0 != ((n == 0) ? 0 : dv * (16 * n + 2))) begin
            bad++;
            $display("FAIL %s cs_low_cycles: got=%0d required=%0d", name, low_cnt[sel] - lc0,
                     (n == 0) ? 0 : dv * (16 * n + 2));
        end
        total++;
        if (rise_cnt[sel] - rc0 != 8 * n || gap_bad[sel] - gb0 != 0) begin
            bad++;
            $display("FAIL %s sclk: rises=%0d bad_intervals=%0d required %0d 0", name,
                     rise_cnt[sel] - rc0, gap_bad[sel] - gb0, 8 * n);
        end
        total++;
        if (done_cnt[sel] - dc0 != 1 || cs_rise[sel] - cr0 != ((n == 0) ? 0 : 1)) begin
            bad++;
            $display("FAIL %s pulses: done=%0d cs_rises=%0d required 1 %0d", name,
                     done_cnt[sel] - dc0, cs_rise[sel] - cr0, (n == 0) ? 0 : 1);
        end
        if (n > 0) begin
            exp_bits = txw >> (8 * (4 - n));
            mask     = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
            total++;
            if ((mosi_cap[sel] & mask) !== exp_bits) begin
                bad++;
                $display("FAIL %s mosi_stream: got=%h required=%h", name, mosi_cap[sel] & mask, exp_bits);
            end
        end
        $display("xfer %-14s div=%0d len=%0d bytes=%0d rx_count=%0d rx=%h_%h_%h_%h cs_low=%0d",
                 name, dv, len, n, cnt_w[sel], rx_w[sel][0], rx_w[sel][1], rx_w[sel][2],
                 rx_w[sel][3], low_cnt[sel] - lc0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            len_s[i] = 3'd0;
            slave_w[i] = 32'h0;
            for (int k = 0; k < 4; k++) begin
                tx_s[i][k]   = 8'h00;
                exp_rx[i][k] = 8'h00;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cs_w[i] !== 1'b1 || sclk_w[i] !== 1'b0 || mosi_w[i] !== 1'b0 || busy_w[i] !== 1'b0 ||
                done_w[i] !== 1'b0 || cnt_w[i] !== 3'd0 || rx_w[i][0] !== 8'h00 || rx_w[i][3] !== 8'h00) begin
                bad++;
                $display("FAIL reset_state[%0d]: cs_n=%b sclk=%b mosi=%b busy=%b done=%b rx_count=%0d required 1 0 0 0 0 0",
                         i, cs_w[i], sclk_w[i], mosi_w[i], busy_w[i], done_w[i], cnt_w[i]);
            end
            $display("xfer reset         div=%0d cs_n=%b rx_count=%0d", div_of(i), cs_w[i], cnt_w[i]);
        end
        rst_s = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int c, r0, dc0;
        slave_w[0] = $urandom;
        loop_s[0]  = 1'b0;
        for (int k = 0; k < 4; k++) tx_s[0][k] = 8'($urandom);
        len_s[0]   = 3'd4;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        for (c = 0; c < 2000 && cnt_w[0] != 3'd2; c++) begin
            @(posedge clk); #1;
        end
        r0 = rise_cnt[0];
        for (c = 0; c < 2000 && (rise_cnt[0] - r0) < 5; c++) begin
            @(posedge clk); #1;
        end
        total++;
        if (cnt_w[0] !== 3'd2 || busy_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_reach: rx_count=%0d busy=%b required 2 1", cnt_w[0], busy_w[0]);
        end
        dc0 = done_cnt[0];
        #2 rst_s[0] = 1'b1;
        #1;
        total++;
        if (cs_w[0] !== 1'b1 || sclk_w[0] !== 1'b0 || cnt_w[0] !== 3'd0 || busy_w[0] !== 1'b0 ||
            mosi_w[0] !== 1'b0 || rx_w[0][0] !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_async: cs_n=%b sclk=%b rx_count=%0d busy=%b mosi=%b rx0=%h required 1 0 0 0 0 00",
                     cs_w[0], sclk_w[0], cnt_w[0], busy_w[0], mosi_w[0], rx_w[0][0]);
        end
        for (int k = 0; k < 4; k++) exp_rx[0][k] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        total++;
        if (done_cnt[0] - dc0 != 0) begin
            bad++;
            $display("FAIL reset_mid_done: pulses=%0d required 0", done_cnt[0] - dc0);
        end
        $display("xfer reset_mid     div=2 rx_count=%0d done_pulses=%0d", cnt_w[0], done_cnt[0] - dc0);
        run_xfer(0, 3'd2, $urandom, $urandom, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_loopback();
        run_xfer(0, 3'd1, 32'hA500_0000, 32'h0, 1'b1, 1'b0, "loopback_a5");
    endtask

    task automatic test_four_bytes();
        run_xfer(0, 3'd4, 32'h0102_0304, 32'hF0E1_D2C3, 1'b0, 1'b0, "four_bytes");
    endtask

    task automatic test_len_bounds();
        run_xfer(0, 3'd0, $urandom, $urandom, 1'b0, 1'b0, "noop_len0");
        run_xfer(0, 3'd6, $urandom, $urandom, 1'b0, 1'b0, "clamp_len6");
    endtask

    task automatic test_ignore_start();
        run_xfer(0, 3'd3, $urandom, $urandom, 1'b0, 1'b1, "start_ignored");
    endtask

    task automatic test_div1();
        run_xfer(1, 3'd2, $urandom, $urandom, 1'b0, 1'b0, "div1_len2");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            run_xfer($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom,
                     1'($urandom_range(0, 1)), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_four_bytes();
        test_len_bounds();
        test_ignore_start();
        test_reset_mid();
        test_div1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_buffer.md
SPI_MASTER_BUFFER -- requirements
Module: spi_master_buffer

Interface
REQ-001 Parameter: CLK_DIV, 4, sys_clk cycles per SCLK half-period; legal range 1..255.
REQ-002 Port: sys_clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  transfer request, sampled only in IDLE.
REQ-005 Port: tx_len  input  3  bytes to transfer; 1..4 legal, 5..7 clamped to 4, 0 means no-op.
REQ-006 Port: tx0..tx3  input  8 each  command bytes, sent tx0 first.
REQ-007 Port: busy  output  1  high from the cycle after start acceptance until done.
REQ-008 Port: done  output  1  one-cycle completion pulse.
REQ-009 Port: rx0..rx3  output  8 each  bytes captured from MISO; rx0 is the first byte.
REQ-010 Port: rx_count  output  3  bytes captured in the current or last transfer.
REQ-011 Port: spi_sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 Port: spi_cs_n  output  1  chip select, active-low.
REQ-013 Port: spi_mosi  output  1  serial data out, MSB first.
REQ-014 Port: spi_miso  input  1  serial data in, MSB first; synchronous to spi_sclk, no synchronizer required.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, XFER, HOLD, with transitions IDLE->SETUP->XFER->HOLD->IDLE.
REQ-016 In IDLE, start=1 SHALL latch tx0..tx3 and the clamped tx_len, clear rx_count, and enter SETUP on the next edge.
REQ-017 Start with tx_len=0 SHALL leave cs_n high, stay in IDLE, and pulse done on the next cycle with rx_count=0.
REQ-018 In SETUP: spi_cs_n=0, spi_sclk=0, spi_mosi=tx0[7], held for CLK_DIV cycles.
REQ-019 In XFER: spi_sclk SHALL toggle every CLK_DIV cycles, starting low.
REQ-020 spi_miso SHALL be sampled on the sys_clk edge that drives spi_sclk high.
REQ-021 spi_mosi SHALL advance to the next bit on the edge that drives spi_sclk low.
REQ-022 Bytes SHALL be sent back-to-back with no inter-byte gap; the next byte's MSB is presented on the 8th falling edge of the current byte.
REQ-023 On the 8th rising edge of byte k, the assembled byte SHALL be written to rx[k] and rx_count SHALL increment in the same cycle.
REQ-024 After the final falling edge, HOLD SHALL keep spi_cs_n=0 and spi_sclk=0 for CLK_DIV cycles.
REQ-025 Leaving HOLD SHALL drive spi_cs_n=1, busy=0, and done=1 for exactly one cycle.
REQ-026 spi_cs_n SHALL be low for exactly CLK_DIV*(16*N+2) cycles, where N is the clamped length.
REQ-027 start while busy=1 SHALL be ignored, with no queuing.
REQ-028 rx0..rx3 and rx_count SHALL hold their values after done until the next accepted start; unwritten rx entries keep their prior values.
REQ-029 spi_sclk, spi_cs_n and spi_mosi SHALL be registered outputs with no glitches.

Reset
REQ-030 While reset=1, all outputs SHALL take these values immediately (asynchronously): spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, rx_count=0, rx0..rx3=8'h00, state=IDLE.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer without a done pulse; start is honored on the first edge after release.

Structure
REQ-032 Package spi_pkg SHALL hold the FSM state enum typedef, SPI_MAX_BYTES=4, and the byte typedef.
REQ-033 Sub-module spi_clk_gen SHALL produce the half-period tick (counter 0..CLK_DIV-1), enabled only outside IDLE.
REQ-034 The bit counter (3 bits) and byte index (2 bits) SHALL wrap naturally, with termination decided by comparison against the latched length.

Verification
REQ-035 CLK_DIV=2, tx_len=1, tx0=8'hA5, MISO loopback -> MOSI pattern 10100101, rx0=8'hA5, rx_count=1, cs_n low for 36 cycles, one done pulse.
REQ-036 tx_len=4, tx=01,02,03,04, slave model returns F0,E1,D2,C3 -> rx0..rx3=F0,E1,D2,C3, 32 rising SCLK edges, no inter-byte gap.
REQ-037 tx_len=0 -> cs_n stays high, done pulse one cycle after start, rx_count=0; tx_len=6 -> exactly 4 bytes transferred.
REQ-038 Second start pulse mid-transfer -> ignored; exactly one done pulse and cs_n remains low continuously.
REQ-039 Reset asserted during bit 5 of byte 2 -> cs_n=1 and sclk=0 the same cycle, rx_count=0, no done pulse; a following transfer completes normally.
REQ-040 CLK_DIV=1 -> SCLK = sys_clk/2, tx_len=2 data correct, cs_n low for 34 cycles.
